// File: rtl/fetch_queue.sv
// Fetch-to-decode decoupling FIFO: holds {pc, instr} pairs in order, stalls the PC when
// full and drops everything on a redirect.
module fetch_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [31:0]   in_pc,
  input  logic [31:0]   in_instr,
  output logic          in_ready,
  output logic          stall_f,
  output logic          out_valid,
  output logic [31:0]   out_pc,
  output logic [31:0]   out_instr,
  input  logic          out_ready,
  input  logic          flush,
  output logic [AW:0]   count
);

  localparam logic [AW:0] CntFull = (AW+1)'(DEPTH);

  logic [31:0]   pc_q    [DEPTH];
  logic [31:0]   instr_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          push, pop;

  // Outputs come from registered state only; no input-to-output paths.
  always_comb begin
    in_ready  = (cnt_q != CntFull);
    stall_f   = ~in_ready;
    out_valid = (cnt_q != '0);
    count     = cnt_q;
    out_pc    = out_valid ? pc_q[rd_ptr_q]    : 32'h0;
    out_instr = out_valid ? instr_q[rd_ptr_q] : 32'h0;
  end

  // Handshakes, gated by flush so a redirect cycle neither captures nor consumes.
  always_comb begin
    push = in_valid & in_ready & ~flush;
    pop  = out_valid & out_ready & ~flush;
  end

  // Next-state for pointers and occupancy; pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      // push is blocked when full and pop when empty, so cnt never leaves 0..DEPTH.
      unique case ({push, pop})
        2'b10:   cnt_d = cnt_q + (AW+1)'(1);
        2'b01:   cnt_d = cnt_q - (AW+1)'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Control state register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: out_* are masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[wr_ptr_q]    <= in_pc;
      instr_q[wr_ptr_q] <= in_instr;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed test-plan steps followed by random traffic,
// all compared against a queue-based reference model.
module tb_fetch_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [31:0]   in_pc;
  logic [31:0]   in_instr;
  logic          in_ready;
  logic          stall_f;
  logic          out_valid;
  logic [31:0]   out_pc;
  logic [31:0]   out_instr;
  logic          out_ready;
  logic          flush;
  logic [AW:0]   count;

  int vectors = 0;
  int errs    = 0;

  // Reference model: FIFO of {pc, instr}.
  logic [63:0] mq[$];

  fetch_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_pc    (in_pc),
    .in_instr (in_instr),
    .in_ready (in_ready),
    .stall_f  (stall_f),
    .out_valid(out_valid),
    .out_pc   (out_pc),
    .out_instr(out_instr),
    .out_ready(out_ready),
    .flush    (flush),
    .count    (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model.
  task automatic check_all(input string tag);
    int n;
    n = mq.size();
    chk({tag, ".count"},     32'(count),     32'(n));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(n != 0));
    chk({tag, ".in_ready"},  32'(in_ready),  32'(n != DEPTH));
    chk({tag, ".stall_f"},   32'(stall_f),   32'(n == DEPTH));
    chk({tag, ".out_pc"},    out_pc,    (n != 0) ? mq[0][63:32] : 32'h0);
    chk({tag, ".out_instr"}, out_instr, (n != 0) ? mq[0][31:0]  : 32'h0);
  endtask

  // One clock cycle: drive at negedge, update model at posedge, check at next negedge.
  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                      input logic ordy, input logic fl, input string tag);
    bit do_push, do_pop;
    in_valid  = v;
    in_pc     = pc;
    in_instr  = ins;
    out_ready = ordy;
    flush     = fl;
    do_push = v && (mq.size() < DEPTH) && !fl;
    do_pop  = ordy && (mq.size() > 0) && !fl;
    @(posedge clk);
    if (fl) mq.delete();
    else begin
      if (do_pop)  void'(mq.pop_front());
      if (do_push) mq.push_back({pc, ins});
    end
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    logic [31:0] rpc;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_pc     = '0;
    in_instr  = '0;
    out_ready = 1'b0;
    flush     = 1'b0;

    // Reset then idle.
    repeat (2) @(negedge clk);
    check_all("reset_held");
    reset = 1'b1;
    step(0, 0, 0, 0, 0, "idle");

    // In-order fill to full.
    for (int k = 0; k < 4; k++)
      step(1, 32'h3000 + 32'(4 * k), 32'h11111111 * 32'(k + 1), 0, 0, "fill");
    chk("full_count", 32'(count), 4);
    chk("full_stall", 32'(stall_f), 1);
    chk("full_head", out_pc, 32'h3000);
    step(1, 32'h3010, 32'h55555555, 0, 0, "full_hold");
    chk("full_hold_count", 32'(count), 4);
    // Pop while full: 0x3010 is not taken this cycle.
    step(1, 32'h3010, 32'h55555555, 1, 0, "drain0");
    chk("drain0_pc", out_pc, 32'h3004);
    chk("drain0_count", 32'(count), 3);
    step(1, 32'h3010, 32'h55555555, 1, 0, "drain1");
    chk("drain1_pc", out_pc, 32'h3008);
    chk("drain1_count", 32'(count), 3);
    step(0, 0, 0, 1, 0, "drain2");
    chk("drain2_pc", out_pc, 32'h300c);
    step(0, 0, 0, 1, 0, "drain3");
    chk("drain3_pc", out_pc, 32'h3010);
    step(0, 0, 0, 1, 0, "drain4");
    chk("drain4_empty", 32'(out_valid), 0);

    // Wrap-around with continuous push and pop.
    for (int k = 0; k < 10; k++) begin
      step(1, 32'h3000 + 32'(4 * k), 32'hA0000000 + 32'(k), 1, 0, "wrap");
      chk("wrap_pc", out_pc, 32'h3000 + 32'(4 * k));
      chk("wrap_count", 32'(count), 1);
    end
    step(0, 0, 0, 1, 0, "wrap_drain");

    // Simultaneous push/pop at cnt=2.
    step(1, 32'h3300, 32'hB0, 0, 0, "pp_fill");
    step(1, 32'h3304, 32'hB1, 0, 0, "pp_fill");
    step(1, 32'h3308, 32'hB2, 1, 0, "pp");
    chk("pp_count", 32'(count), 2);
    chk("pp_head", out_pc, 32'h3304);

    // Flush mid-stream with 3 queued.
    step(1, 32'h330c, 32'hB3, 0, 0, "fl_fill");
    chk("fl_pre_count", 32'(count), 3);
    step(1, 32'h3100, 32'hC0, 1, 1, "flush");
    chk("flush_count", 32'(count), 0);
    chk("flush_valid", 32'(out_valid), 0);
    step(1, 32'h3200, 32'hC1, 0, 0, "post_flush");
    chk("post_flush_pc", out_pc, 32'h3200);
    chk("post_flush_count", 32'(count), 1);
    step(0, 0, 0, 1, 0, "post_flush_drain");
    chk("no_3100", 32'(out_valid), 0);

    // Asynchronous reset with 2 queued, dropped between edges.
    step(1, 32'h3500, 32'hD0, 0, 0, "ar_fill");
    step(1, 32'h3504, 32'hD1, 0, 0, "ar_fill");
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("async_valid", 32'(out_valid), 0);
    chk("async_count", 32'(count), 0);
    mq.delete();
    @(negedge clk);
    reset = 1'b1;
    check_all("async_release");

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      rpc = 32'h4000 + 32'(4 * i);
      step(($urandom % 4) != 0, rpc, $urandom, ($urandom % 3) != 0,
           ($urandom % 16) == 0, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Decoupling buffer between the fetch stage (PC plus instruction memory read) and the decode stage.
- Captures {pc, instr} pairs produced by fetch and presents them in order to decode with a valid/ready handshake.
- Back-pressures the PC with a stall when full.
- Drops all buffered entries on a control-flow redirect (flush).

Parameters:
- DEPTH, 4, number of entries; must be a power of two, at least 2.
- AW, 2, pointer width, equal to log2(DEPTH).

Ports:
- clk  input  1  system clock, all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; reset=0 clears all state immediately.
- in_valid  input  1  fetch presents a valid pc/instr pair this cycle.
- in_pc  input  32  address of the fetched instruction.
- in_instr  input  32  fetched instruction word.
- in_ready  output  1  queue can accept a push this cycle.
- stall_f  output  1  equal to ~in_ready; drives the PC stall input.
- out_valid  output  1  head entry is valid.
- out_pc  output  32  PC of the head entry.
- out_instr  output  32  instruction of the head entry.
- out_ready  input  1  decode consumes the head entry this cycle.
- flush  input  1  redirect: discard all entries and the push of this cycle.
- count  output  AW+1  number of occupied entries, 0..DEPTH.

Behaviour:
- State:
  - Storage arrays pc_q[DEPTH], instr_q[DEPTH].
  - Pointers wr_ptr and rd_ptr, each AW bits.
  - Occupancy counter cnt, AW+1 bits.
- Reset (reset=0, asynchronous):
  - wr_ptr=0, rd_ptr=0, cnt=0.
  - Hence out_valid=0, in_ready=1, stall_f=0, count=0, out_pc=0, out_instr=0.
  - Storage contents need not be cleared.
  - Reset asserted mid-operation discards all entries immediately, without waiting for clk.
- Combinational outputs, all derived from registered state only, with no input-to-output paths:
  - in_ready = (cnt != DEPTH).
  - out_valid = (cnt != 0).
  - count = cnt.
  - out_pc = out_valid ? pc_q[rd_ptr] : 32'h0.
  - out_instr = out_valid ? instr_q[rd_ptr] : 32'h0 (sll nop).
- Push condition: push = in_valid & in_ready & ~flush.
  - On a push, write in_pc/in_instr at wr_ptr and increment wr_ptr.
- Pop condition: pop = out_valid & out_ready & ~flush.
  - On a pop, increment rd_ptr.
- Counter update:
  - Push only: cnt+1.
  - Pop only: cnt-1.
  - Push and pop together: cnt unchanged, both pointers advance.
  - Neither: hold.
- Pointer wrap: DEPTH-1 to 0, natural AW-bit overflow.
- Latency: a pushed entry appears on out_* on the cycle after the push edge. There is no same-cycle bypass when empty.
- Full queue:
  - in_ready=0, so no push even if a pop occurs that same cycle. The freed slot becomes pushable on the next cycle.
  - in_valid while full is ignored; fetch must hold the pair (the PC stalls via stall_f).
- Empty queue: out_ready is ignored; no pop, and the pointers do not move.
- Flush, which takes priority over everything:
  - At the next edge: wr_ptr=0, rd_ptr=0, cnt=0.
  - Any push and pop in that cycle is suppressed.
  - The cycle after a flush has out_valid=0 and in_ready=1.
- Simultaneous flush and reset: reset dominates; the result is the same empty state.
- Overflow and underflow of cnt must be impossible by construction.

Test Plan:
- Reset then idle:
  - Stimulus: reset=0 for 2 cycles, then release.
  - Required response: out_valid=0, in_ready=1, stall_f=0, count=0, out_instr=0.
- In-order fill and drain:
  - Stimulus: out_ready=0; push pc=0x3000/0x3004/0x3008/0x300c with instrs 0x11111111..0x44444444.
  - Required: count=4, in_ready=0, stall_f=1.
  - Then: hold in_valid=1 with pc=0x3010.
  - Required: not accepted, count stays 4.
  - Then: out_ready=1.
  - Required: out_pc reads 0x3000, 0x3004, 0x3008, 0x300c on consecutive cycles; the 0x3010 pair is accepted one cycle after the first pop.
- Wrap-around:
  - Stimulus: continuous push and pop with out_ready=1 for 10 entries, pc=0x3000+4k.
  - Required: out_pc sequence strictly 0x3000..0x3024; count settles at 1 in steady state; order is preserved across pointer wrap.
- Simultaneous push/pop at cnt=2:
  - Required: count stays 2 and the head advances by one entry.
- Flush mid-stream:
  - Stimulus: with 3 entries queued, assert flush for 1 cycle while in_valid=1 (pc=0x3100).
  - Required: the next cycle has count=0, out_valid=0, and 0x3100 was not captured.
  - Then: push pc=0x3200.
  - Required: out_pc=0x3200 one cycle later.
- Asynchronous reset mid-operation:
  - Stimulus: with 2 entries queued, drop reset between clock edges.
  - Required: out_valid=0 and count=0 before the next rising edge.
